// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD to Excess-3 datapath.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] XS3_INVALID = 4'h0;
  localparam logic [3:0] BCD_MAX     = 4'd9;

  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_excess3.sv
// Single-digit BCD to Excess-3 converter; non-BCD codes map to the invalid marker.
module bcd_to_excess3
  import bcd_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [3:0] xs3_o
);

  always_comb begin
    xs3_o = bcd_digit_ok(bcd_i) ? (bcd_i + 4'd3) : XS3_INVALID;
  end

endmodule

// File: rtl/bcd_xs3_seq.sv
// Multi-digit BCD to Excess-3 sequencer: one digit per cycle through a shared converter.
module bcd_xs3_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_xs3,
  output logic                  out_err,
  output logic                  busy
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [W-1:0]    src_q, src_d;
  logic [W-1:0]    res_q, res_d;

  logic [3:0]      conv_xs3;
  logic [3:0]      digit_xs3;
  logic            nib_ok;
  logic            accept;
  logic [W-1:0]    nib_ext;

  bcd_to_excess3 u_conv (
    .bcd_i (src_q[3:0]),
    .xs3_o (conv_xs3)
  );

  assign nib_ok    = bcd_digit_ok(src_q[3:0]);
  assign digit_xs3 = nib_ok ? conv_xs3 : XS3_INVALID;
  assign in_ready  = rst_n && (state_q == IDLE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    src_d   = src_q;
    res_d   = res_q;
    // Converted nibble enters at the top so digit 0 ends in [3:0] after DIGITS shifts.
    nib_ext = '0;
    nib_ext[W-4 +: 4] = digit_xs3;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CONV;
          cnt_d   = '0;
          err_d   = 1'b0;
          src_d   = in_bcd;
          res_d   = '0;
        end
      end
      CONV: begin
        src_d = src_q >> 4;
        res_d = (res_q >> 4) | nib_ext;
        err_d = err_q | ~nib_ok;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q <= '0;
      res_q <= '0;
    end else begin
      src_q <= src_d;
      res_q <= res_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_xs3   = res_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_bcd_xs3_seq.sv
// Scoreboard bench for bcd_xs3_seq with DIGITS=4.
module tb_bcd_xs3_seq;

  localparam int unsigned DIGITS = 4;

  typedef struct packed {
    logic [15:0] xs3;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_xs3;
  logic        out_err;
  logic        busy;

  exp_t        sb[$];
  int unsigned rises[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  logic        prev_ov = 1'b0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  bcd_xs3_seq #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xs3   (out_xs3),
    .out_err   (out_err),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] bcd);
    exp_t e;
    logic [3:0] d;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      d = bcd[4*i +: 4];
      if (d > 4'd9) begin
        e.xs3[4*i +: 4] = 4'h0;
        e.err = 1'b1;
      end else begin
        e.xs3[4*i +: 4] = d + 4'd3;
      end
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (out_valid && !prev_ov) rises.push_back(cyc);
      prev_ov = out_valid;
      if (sb.size() == 0) begin
        chk("spurious_valid", {31'd0, out_valid}, 32'd0);
      end else if (out_valid && out_ready) begin
        e = sb.pop_front();
        chk("xs3", {16'd0, out_xs3}, {16'd0, e.xs3});
        chk("err", {31'd0, out_err}, {31'd0, e.err});
      end
    end
  end

  // Leaves in_valid high; returns 1ns after the accept edge.
  task automatic send(input logic [15:0] w, input bit push, input exp_t e);
    int unsigned n = 0;
    in_bcd   = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_empty(input int unsigned bound);
    int unsigned n = 0;
    while (sb.size() > 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_xs3"},   {16'd0, out_xs3},   32'd0);
    chk({tag, "_out_err"},   {31'd0, out_err},   32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vin  [4] = '{16'h9090, 16'h0000, 16'h12A9, 16'hFFFF};
    logic [15:0] vxs3 [4] = '{16'hC3C3, 16'h3333, 16'h450C, 16'h0000};
    logic        verr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int unsigned n;
    logic [15:0] w;

    rst_n = 1'b0; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    mon_en = 1'b1;

    // Basic word with latency and busy tracking
    send(16'h1234, 1'b1, '{xs3: 16'h4567, err: 1'b0});
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk("latency_valid", {31'd0, out_valid}, (k == 4) ? 32'd1 : 32'd0);
      chk("busy_conv", {31'd0, busy}, 32'd1);
    end
    wait_empty(20);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);

    // Boundary and invalid digits
    for (int i = 0; i < 4; i++) begin
      send(vin[i], 1'b1, '{xs3: vxs3[i], err: verr[i]});
      in_valid = 1'b0;
      wait_empty(20);
    end

    // Random words against the digit model
    for (int i = 0; i < 4; i++) begin
      w = 16'($urandom);
      send(w, 1'b1, model(w));
      in_valid = 1'b0;
      wait_empty(20);
    end

    // Backpressure in DONE with ignored input pulses
    out_ready = 1'b0;
    send(16'h2468, 1'b1, '{xs3: 16'h579B, err: 1'b0});
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_bcd   = 16'h5555;
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready},  32'd0);
      chk("bp_valid",    {31'd0, out_valid}, 32'd1);
      chk("bp_xs3",      {16'd0, out_xs3},   32'h579B);
      chk("bp_err",      {31'd0, out_err},   32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty(20);
    chk("bp_back_idle", {31'd0, in_ready}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_accept", {31'd0, busy}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Reset asserted at the second CONV edge discards the word
    send(16'h7777, 1'b0, '0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    send(16'h0001, 1'b1, '{xs3: 16'h3334, err: 1'b0});
    in_valid = 1'b0;
    wait_empty(20);

    // Back-to-back with in_valid and out_ready held high
    rises.delete();
    out_ready = 1'b1;
    send(16'h0123, 1'b1, '{xs3: 16'h3456, err: 1'b0});
    send(16'h4567, 1'b1, '{xs3: 16'h789A, err: 1'b0});
    in_valid = 1'b0;
    wait_empty(30);
    chk("b2b_rises", rises.size(), 32'd2);
    if (rises.size() >= 2) chk("b2b_spacing", rises[1] - rises[0], 32'd6);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
